// File: rtl/fpu_rr_scheduler.sv
// fpu_rr_scheduler: shares one fixed-latency fpu between N_REQ requesters.
// A round-robin arbiter issues at most one operation per cycle. A tag pipeline
// as deep as the fpu latency carries each requester id alongside its operation,
// so that every result returns to its originator.
module fpu_rr_scheduler #(
    parameter int N_REQ       = 4,
    parameter int FPU_LATENCY = 3,
    parameter int ID_W        = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    input  logic [2*N_REQ-1:0]   req_op,
    output logic [31:0]          fpu_a,
    output logic [31:0]          fpu_b,
    output logic [1:0]           fpu_op,
    input  logic [31:0]          fpu_o,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_data,
    output logic [ID_W+1:0]      in_flight,
    input  logic                 issue_en
);

    // One tag stage per fpu latency edge, plus the stage loaded at issue.
    localparam int STAGES = FPU_LATENCY + 1;

    logic [ID_W-1:0]             ptr;
    logic                        handshake;
    logic [ID_W-1:0]             grantId;
    logic [ID_W:0]               probe;
    logic [ID_W-1:0]             probeId;
    logic [31:0]                 selA;
    logic [31:0]                 selB;
    logic [1:0]                  selOp;
    logic [STAGES-1:0]           tagValid;
    logic [STAGES-1:0][ID_W-1:0] tagId;
    logic                        tailValid;
    logic [ID_W-1:0]             tailId;

    assign tailValid = tagValid[STAGES-1];
    assign tailId    = tagId[STAGES-1];
    assign rsp_data  = fpu_o;

    // Round-robin search starting at ptr; the first valid requester wins.
    always_comb begin
        req_ready = '0;
        handshake = 1'b0;
        grantId   = '0;
        probe     = '0;
        probeId   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            probe = {1'b0, ptr} + (ID_W+1)'(k);
            if (probe >= (ID_W+1)'(N_REQ)) begin
                probe = probe - (ID_W+1)'(N_REQ);
            end
            probeId = probe[ID_W-1:0];
            if (!handshake && req_valid[probeId] && issue_en && !reset) begin
                handshake = 1'b1;
                grantId   = probeId;
            end
        end
        if (handshake) begin
            req_ready[grantId] = 1'b1;
        end
    end

    // Pick the granted requester's operand and opcode slices.
    always_comb begin
        selA  = '0;
        selB  = '0;
        selOp = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (handshake && grantId == ID_W'(i)) begin
                selA  = req_a[32*i +: 32];
                selB  = req_b[32*i +: 32];
                selOp = req_op[2*i +: 2];
            end
        end
    end

    // Register the granted operation into the fpu and move priority past the winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpu_a  <= '0;
            fpu_b  <= '0;
            fpu_op <= '0;
            ptr    <= '0;
        end else if (handshake) begin
            fpu_a  <= selA;
            fpu_b  <= selB;
            fpu_op <= selOp;
            ptr    <= (grantId == ID_W'(N_REQ-1)) ? '0 : grantId + ID_W'(1);
        end
    end

    // Shift the issue tags alongside the fpu so the tail lines up with fpu_o.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tagValid <= '0;
            tagId    <= '0;
        end else begin
            tagValid <= {tagValid[STAGES-2:0], handshake};
            tagId    <= {tagId[STAGES-2:0], grantId};
        end
    end

    // Count operations issued but not yet returned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_flight <= '0;
        end else begin
            case ({handshake, tailValid})
                2'b10:   in_flight <= in_flight + (ID_W+2)'(1);
                2'b01:   in_flight <= in_flight - (ID_W+2)'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Decode the tail tag into the one-hot response strobe and encoded id.
    always_comb begin
        rsp_valid = '0;
        rsp_id    = '0;
        if (tailValid) begin
            rsp_valid[tailId] = 1'b1;
            rsp_id            = tailId;
        end
    end

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// tb_fpu_rr_scheduler: randomized and directed scenarios for fpu_rr_scheduler,
// checked against a transaction-level model (issue list plus priority pointer)
// and a behavioural fixed-latency fpu built from real arithmetic.
module tb_fpu_rr_scheduler;

    localparam int N    = 4;
    localparam int LAT  = 3;
    localparam int ID_W = $clog2(N);

    typedef struct packed {
        logic [N-1:0]    ready;
        logic [N-1:0]    rspValid;
        logic [ID_W-1:0] rspId;
        logic [31:0]     rspData;
        logic [ID_W+1:0] inFlight;
        logic [31:0]     fpuA;
        logic [31:0]     fpuB;
        logic [1:0]      fpuOp;
    } obs_t;

    typedef struct {
        int          edgeNo;
        int          id;
        logic [31:0] res;
    } issue_t;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [2*N-1:0]    req_op;
    logic [31:0]       fpu_a;
    logic [31:0]       fpu_b;
    logic [1:0]        fpu_op;
    logic [31:0]       fpu_o;
    logic [N-1:0]      rsp_valid;
    logic [ID_W-1:0]   rsp_id;
    logic [31:0]       rsp_data;
    logic [ID_W+1:0]   in_flight;
    logic              issue_en;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          edgeNo = 0;
    int          mPtr   = 0;
    logic [31:0] mA     = '0;
    logic [31:0] mB     = '0;
    logic [1:0]  mOp    = '0;
    issue_t      mIss[$];

    // Behavioural fpu pipeline
    logic [31:0] p0 = '0;
    logic [31:0] p1 = '0;
    logic [31:0] p2 = '0;

    fpu_rr_scheduler #(.N_REQ(N), .FPU_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_o(fpu_o),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .in_flight(in_flight), .issue_en(issue_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real sp2real(input logic [31:0] v);
        logic [63:0] d;
        if (v[30:23] == 8'd0) return 0.0;
        d = {v[31], 11'(v[30:23]) + 11'd896, v[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e <= 11'd896) return {d[63], 31'd0};
        if (e >= 11'd1151) return {d[63], 8'hFF, 23'd0};
        return {d[63], 8'(e - 11'd896), d[51:29]};
    endfunction

    // 00 add, 01 sub, 10 mul, 11 div (truncating single precision)
    function automatic logic [31:0] fpuFunc(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        real ra, rb, r;
        ra = sp2real(a);
        rb = sp2real(b);
        case (op)
            2'b00:   r = ra + rb;
            2'b01:   r = ra - rb;
            2'b10:   r = ra * rb;
            default: r = ra / rb;
        endcase
        return real2sp(r);
    endfunction

    function automatic logic [31:0] randFp();
        logic [31:0] v;
        v = $urandom;
        v[30:23] = 8'($urandom_range(120, 134));
        return v;
    endfunction

    // fpu with LAT edges from stable operands to valid result
    always @(posedge clk) begin
        p0 <= fpuFunc(fpu_a, fpu_b, fpu_op);
        p1 <= p0;
        p2 <= p1;
    end
    assign fpu_o = p2;

    task automatic modelReset();
        mPtr = 0;
        mA   = '0;
        mB   = '0;
        mOp  = '0;
        mIss.delete();
    endtask

    // Drive one cycle, predict every output from the model, observe the DUT at
    // the falling edge, then advance the model past the rising edge.
    task automatic stepCycle(input logic [N-1:0] valid, input logic en, input bit randOps,
                             output obs_t got, output obs_t exp);
        int g;
        int idx;
        issue_t t;
        if (randOps) begin
            for (int i = 0; i < N; i++) begin
                req_a[32*i +: 32] = randFp();
                req_b[32*i +: 32] = randFp();
                req_op[2*i +: 2]  = 2'($urandom_range(0, 3));
            end
        end
        req_valid = valid;
        issue_en  = en;
        g = -1;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                idx = (mPtr + k) % N;
                if (g < 0 && valid[idx]) g = idx;
            end
        end
        exp = '0;
        if (g >= 0) exp.ready[g] = 1'b1;
        exp.fpuA  = mA;
        exp.fpuB  = mB;
        exp.fpuOp = mOp;
        foreach (mIss[i]) begin
            if (mIss[i].edgeNo == edgeNo - LAT) begin
                exp.rspValid[mIss[i].id] = 1'b1;
                exp.rspId   = ID_W'(mIss[i].id);
                exp.rspData = mIss[i].res;
            end
            if (mIss[i].edgeNo >= edgeNo - LAT) exp.inFlight = exp.inFlight + 1'b1;
        end
        @(negedge clk);
        got.ready    = req_ready;
        got.rspValid = rsp_valid;
        got.rspId    = rsp_id;
        got.rspData  = (exp.rspValid != '0) ? rsp_data : 32'd0;
        got.inFlight = in_flight;
        got.fpuA     = fpu_a;
        got.fpuB     = fpu_b;
        got.fpuOp    = fpu_op;
        @(posedge clk);
        #1;
        edgeNo++;
        if (g >= 0) begin
            t.edgeNo = edgeNo;
            t.id     = g;
            t.res    = fpuFunc(req_a[32*g +: 32], req_b[32*g +: 32], req_op[2*g +: 2]);
            mIss.push_back(t);
            mA   = req_a[32*g +: 32];
            mB   = req_b[32*g +: 32];
            mOp  = req_op[2*g +: 2];
            mPtr = (g + 1) % N;
        end
        while (mIss.size() > 0 && mIss[0].edgeNo < edgeNo - LAT) void'(mIss.pop_front());
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '1;
        issue_en  = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({req_ready, rsp_valid, rsp_id, fpu_a, fpu_b, fpu_op, in_flight} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs ready=%b rsp=%b id=%0d a=%h b=%h op=%b inflight=%0d required all zero",
                     req_ready, rsp_valid, rsp_id, fpu_a, fpu_b, fpu_op, in_flight);
        end
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        edgeNo++;
    endtask

    task automatic test_single_op();
        obs_t got, exp;
        req_a[31:0] = 32'h3F800000;
        req_b[31:0] = 32'h40000000;
        req_op[1:0] = 2'b00;
        for (int c = 1; c <= 6; c++) begin
            stepCycle((c == 1) ? 4'b0001 : 4'b0000, 1'b1, c != 1, got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL single_op cyc=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == 2) begin
                checks++;
                if (got.fpuA !== 32'h3F800000 || got.inFlight !== 4'd1) begin
                    failures++;
                    $display("[TB] FAIL single_op_issue fpu_a=%h inflight=%0d required 3f800000/1", got.fpuA, got.inFlight);
                end
            end
            if (c == 5) begin
                checks++;
                if (got.rspValid !== 4'b0001 || got.rspId !== 2'd0 || got.rspData !== 32'h40400000) begin
                    failures++;
                    $display("[TB] FAIL single_op_rsp valid=%b id=%0d data=%h required 0001/0/40400000",
                             got.rspValid, got.rspId, got.rspData);
                end
            end
            if (c == 6) begin
                checks++;
                if (got.inFlight !== 4'd0) begin
                    failures++;
                    $display("[TB] FAIL single_op_drain inflight=%0d required 0", got.inFlight);
                end
            end
        end
    endtask

    task automatic test_all_valid();
        obs_t got, exp;
        int   maxIf = 0;
        int   start;
        start = mPtr;
        for (int c = 0; c < 8 + LAT + 1; c++) begin
            stepCycle((c < 8) ? 4'b1111 : 4'b0000, 1'b1, 1'b1, got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL all_valid cyc=%0d got=%h exp=%h", c, got, exp);
            end
            if (c < 8) begin
                checks++;
                if (got.ready !== 4'(1 << ((start + c) % N))) begin
                    failures++;
                    $display("[TB] FAIL all_valid_rotation cyc=%0d got=%b required=%b",
                             c, got.ready, 4'(1 << ((start + c) % N)));
                end
            end
            if (int'(got.inFlight) > maxIf) maxIf = int'(got.inFlight);
        end
        checks++;
        if (maxIf != LAT + 1) begin
            failures++;
            $display("[TB] FAIL all_valid_saturation max_in_flight=%0d required=%0d", maxIf, LAT + 1);
        end
    endtask

    task automatic test_ptr_wrap();
        obs_t got, exp;
        logic [N-1:0] pattern [4];
        logic [N-1:0] want [4];
        pattern = '{4'b0010, 4'b1010, 4'b1010, 4'b1111};
        want    = '{4'b0010, 4'b1000, 4'b0010, 4'b0100};
        for (int c = 0; c < 4 + LAT + 1; c++) begin
            stepCycle((c < 4) ? pattern[c] : 4'b0000, 1'b1, 1'b1, got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL ptr_wrap cyc=%0d got=%h exp=%h", c, got, exp);
            end
            if (c < 4) begin
                checks++;
                if (got.ready !== want[c]) begin
                    failures++;
                    $display("[TB] FAIL ptr_wrap_grant cyc=%0d got=%b required=%b", c, got.ready, want[c]);
                end
            end
        end
    endtask

    task automatic test_issue_en();
        obs_t got, exp;
        int   resumeAt;
        for (int c = 0; c < 3 + LAT + 2; c++) begin
            stepCycle(4'b1111, c < 3, 1'b1, got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL issue_en_off cyc=%0d got=%h exp=%h", c, got, exp);
            end
        end
        checks++;
        if (got.inFlight !== '0 || got.rspValid !== '0 || got.ready !== '0) begin
            failures++;
            $display("[TB] FAIL issue_en_drained inflight=%0d rsp=%b ready=%b required 0/0000/0000",
                     got.inFlight, got.rspValid, got.ready);
        end
        resumeAt = mPtr;
        stepCycle(4'b1111, 1'b1, 1'b1, got, exp);
        checks++;
        if (got.ready !== 4'(1 << resumeAt)) begin
            failures++;
            $display("[TB] FAIL issue_en_resume got=%b required=%b", got.ready, 4'(1 << resumeAt));
        end
        for (int c = 0; c < LAT + 1; c++) begin
            stepCycle(4'b0000, 1'b1, 1'b1, got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL issue_en_resume_drain cyc=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t got, exp;
        for (int c = 0; c < 3; c++) stepCycle(4'b1111, 1'b1, 1'b1, got, exp);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_id, fpu_a, fpu_b, fpu_op, in_flight} !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset ready=%b rsp=%b id=%0d a=%h b=%h op=%b inflight=%0d required all zero",
                     req_ready, rsp_valid, rsp_id, fpu_a, fpu_b, fpu_op, in_flight);
        end
        @(posedge clk);
        #1;
        edgeNo++;
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        edgeNo++;
        for (int c = 0; c < LAT + 2; c++) begin
            stepCycle(4'b0000, 1'b1, 1'b1, got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL async_reset_quiet cyc=%0d got=%h exp=%h", c, got, exp);
            end
        end
        stepCycle(4'b1111, 1'b1, 1'b1, got, exp);
        checks++;
        if (got.ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL async_reset_first_grant got=%b required=0001", got.ready);
        end
        for (int c = 0; c < LAT + 1; c++) stepCycle(4'b0000, 1'b1, 1'b1, got, exp);
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        int   hits = 0;
        for (int c = 0; c < 5 + LAT + 1; c++) begin
            stepCycle((c < 5) ? 4'b0100 : 4'b0000, 1'b1, 1'b1, got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL back_to_back cyc=%0d got=%h exp=%h", c, got, exp);
            end
            if (got.rspValid === 4'b0100 && got.rspId === 2'd2 && got.rspData === exp.rspData) hits++;
        end
        checks++;
        if (hits != 5) begin
            failures++;
            $display("[TB] FAIL back_to_back_count got=%0d required=5", hits);
        end
    endtask

    task automatic test_random();
        obs_t got, exp;
        for (int c = 0; c < 300; c++) begin
            stepCycle(4'($urandom), ($urandom_range(0, 7) != 0), 1'b1, got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL random cyc=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_all_valid();
        test_ptr_wrap();
        test_issue_en();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
